fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a one-cycle-latency synchronous FIFO into a valid/ready beat stream,
// framing every PKT_LEN words as a packet and counting completed packets.
module fifo_stream_reader #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rd_data_i,
    output logic             fifo_rd_en_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    output logic [15:0]      pkt_cnt_o
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [1:0]        occ_reg;
    logic [1:0]        occ_next;
    logic              inflight_reg;
    logic              head_reg;
    logic              head_next;
    logic [BEAT_W-1:0] beat_reg;
    logic [BEAT_W-1:0] beat_next;
    logic [15:0]       pkt_cnt_reg;
    logic [15:0]       pkt_cnt_next;
    logic [WIDTH-1:0]  entry_data [2];

    logic       pop;
    logic       capture;
    logic       wr_slot;
    logic [2:0] pending;

    assign m_valid_o = (occ_reg != 2'd0);
    assign pop       = m_valid_o && m_ready_i;
    assign capture   = inflight_reg;

    // Words that will occupy the buffer after this edge if no further read
    // lands; a new read is only safe while that leaves room for its data.
    assign pending      = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fifo_rd_en_o = !rst_i && !fifo_empty_i && (pending <= 3'd1);

    // Tail slot sits occ entries behind the head; with occ=2 and a pop this
    // is the slot being vacated, so capture and pop can share an edge.
    assign wr_slot = head_reg ^ occ_reg[0];

    assign m_data_o  = entry_data[head_reg];
    assign m_last_o  = m_valid_o && (beat_reg == LAST_BEAT);
    assign pkt_cnt_o = pkt_cnt_reg;

    always_comb begin
        occ_next = occ_reg;
        if (capture && !pop) begin
            occ_next = occ_reg + 2'd1;
        end else if (!capture && pop) begin
            occ_next = occ_reg - 2'd1;
        end

        head_next = pop ? ~head_reg : head_reg;

        beat_next = beat_reg;
        if (pop) begin
            beat_next = (beat_reg == LAST_BEAT) ? '0 : beat_reg + BEAT_W'(1);
        end

        pkt_cnt_next = (pop && m_last_o) ? pkt_cnt_reg + 16'd1 : pkt_cnt_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            head_reg     <= 1'b0;
            beat_reg     <= '0;
            pkt_cnt_reg  <= 16'd0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd_en_o;
            head_reg     <= head_next;
            beat_reg     <= beat_next;
            pkt_cnt_reg  <= pkt_cnt_next;
        end
    end

    // Entries are cleared on reset so an idle output reads as zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                data_reg <= '0;
            end else if (capture && (wr_slot == 1'(gi))) begin
                data_reg <= fifo_rd_data_i;
            end
        end

        assign entry_data[gi] = data_reg;
    end

endmodule
